// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/ack handshake and
// registers {instruction, PC, PC+4} toward decode, honouring redirects and freezes.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] Alt_PC_IN,
    input  logic        Request_Alt_PC_IN,
    input  logic        WANT_FREEZE_IN,
    output logic        Imem_Req_OUT,
    output logic [31:0] Imem_Addr_OUT,
    input  logic        Imem_Ack_IN,
    input  logic [31:0] Imem_Data_IN,
    output logic [31:0] Instr1_OUT,
    output logic [31:0] Instr_PC_OUT,
    output logic [31:0] Instr_PC_Plus4_OUT
);

    typedef enum logic [1:0] {StIdle, StReq, StHold} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ipc_q, ipc_d;
    logic [31:0] ipc4_q, ipc4_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic        squash_q, squash_d;
    logic [31:0] pend_q, pend_d;

    logic [31:0] alt_pc;
    logic [31:0] pc_plus4;

    assign alt_pc   = {Alt_PC_IN[31:2], 2'b00};
    assign pc_plus4 = pc_q + 32'd4;

    assign Imem_Req_OUT       = (state_q == StReq);
    assign Imem_Addr_OUT      = pc_q;
    assign Instr1_OUT         = instr_q;
    assign Instr_PC_OUT       = ipc_q;
    assign Instr_PC_Plus4_OUT = ipc4_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        ipc_d        = ipc_q;
        ipc4_d       = ipc4_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        squash_d     = squash_q;
        pend_d       = pend_q;
        // Unfrozen cycles deliver a bubble unless an instruction is written below.
        if (!WANT_FREEZE_IN) begin
            instr_d = '0;
        end
        unique case (state_q)
            StIdle: begin
                state_d = StReq;
                if (Request_Alt_PC_IN) begin
                    pc_d = alt_pc;
                end
            end
            StReq: begin
                if (Request_Alt_PC_IN) begin
                    if (Imem_Ack_IN) begin
                        pc_d     = alt_pc;
                        squash_d = 1'b0;
                    end else begin
                        // Keep the outstanding request stable; drop its word when it lands.
                        squash_d = 1'b1;
                        pend_d   = alt_pc;
                    end
                end else if (Imem_Ack_IN) begin
                    if (squash_q) begin
                        squash_d = 1'b0;
                        pc_d     = pend_q;
                    end else begin
                        pc_d = pc_plus4;
                        if (WANT_FREEZE_IN) begin
                            hold_instr_d = Imem_Data_IN;
                            hold_pc_d    = pc_q;
                            state_d      = StHold;
                        end else begin
                            instr_d = Imem_Data_IN;
                            ipc_d   = pc_q;
                            ipc4_d  = pc_plus4;
                        end
                    end
                end
            end
            StHold: begin
                if (Request_Alt_PC_IN) begin
                    pc_d         = alt_pc;
                    hold_instr_d = '0;
                    hold_pc_d    = '0;
                    state_d      = StReq;
                end else if (!WANT_FREEZE_IN) begin
                    instr_d = hold_instr_q;
                    ipc_d   = hold_pc_q;
                    ipc4_d  = hold_pc_q + 32'd4;
                    state_d = StReq;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q      <= StIdle;
            pc_q         <= RESET_PC;
            instr_q      <= '0;
            ipc_q        <= '0;
            ipc4_q       <= 32'd4;
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
            squash_q     <= 1'b0;
            pend_q       <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            ipc_q        <= ipc_d;
            ipc4_q       <= ipc4_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            squash_q     <= squash_d;
            pend_q       <= pend_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; memory returns 32'hE000_0000 | address for every word.
module tb_instr_fetch_unit;

    logic        CLK;
    logic        RESET;
    logic [31:0] Alt_PC_IN;
    logic        Request_Alt_PC_IN;
    logic        WANT_FREEZE_IN;
    logic        Imem_Req_OUT;
    logic [31:0] Imem_Addr_OUT;
    logic        Imem_Ack_IN;
    logic [31:0] Imem_Data_IN;
    logic [31:0] Instr1_OUT;
    logic [31:0] Instr_PC_OUT;
    logic [31:0] Instr_PC_Plus4_OUT;

    int nvec = 0;
    int nerr = 0;

    // One row: stimulus applied for a cycle, then the full output vector expected after the edge.
    typedef struct packed {
        logic        ack;
        logic        frz;
        logic        redir;
        logic [31:0] alt;
        logic [128:0] exp;
    } row_t;

    instr_fetch_unit #(.RESET_PC(32'h0040_0000)) dut (
        .CLK                (CLK),
        .RESET              (RESET),
        .Alt_PC_IN          (Alt_PC_IN),
        .Request_Alt_PC_IN  (Request_Alt_PC_IN),
        .WANT_FREEZE_IN     (WANT_FREEZE_IN),
        .Imem_Req_OUT       (Imem_Req_OUT),
        .Imem_Addr_OUT      (Imem_Addr_OUT),
        .Imem_Ack_IN        (Imem_Ack_IN),
        .Imem_Data_IN       (Imem_Data_IN),
        .Instr1_OUT         (Instr1_OUT),
        .Instr_PC_OUT       (Instr_PC_OUT),
        .Instr_PC_Plus4_OUT (Instr_PC_Plus4_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign Imem_Data_IN = 32'hE000_0000 | Imem_Addr_OUT;

    function automatic logic [128:0] obs();
        return {Imem_Req_OUT, Imem_Addr_OUT, Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT};
    endfunction

    function automatic logic [128:0] e(input logic req, input logic [31:0] addr,
                                       input logic [31:0] instr, input logic [31:0] pc,
                                       input logic [31:0] pc4);
        return {req, addr, instr, pc, pc4};
    endfunction

    function automatic row_t r(input logic ack, input logic frz, input logic redir,
                               input logic [31:0] alt, input logic [128:0] exp);
        return '{ack: ack, frz: frz, redir: redir, alt: alt, exp: exp};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        logic [128:0] want;
        RESET = 1'b1;
        #2 RESET = 1'b0;
        #1;
        want = e(1'b0, 32'h0040_0000, 32'h0, 32'h0, 32'h4);
        if (obs() !== want) begin
            $display("FAIL reset_state act=%h exp=%h", obs(), want);
            nerr++;
        end
        nvec++;
        tick();
        RESET = 1'b1;
        #1;
        if (obs() !== want) begin
            $display("FAIL reset_idle act=%h exp=%h", obs(), want);
            nerr++;
        end
        nvec++;
        tick();
        want = e(1'b1, 32'h0040_0000, 32'h0, 32'h0, 32'h4);
        if (obs() !== want) begin
            $display("FAIL reset_first_req act=%h exp=%h", obs(), want);
            nerr++;
        end
        nvec++;
    endtask

    task automatic test_stream();
        row_t rows[4];
        rows[0] = r(1, 0, 0, 0, e(1, 32'h0040_0004, 32'hE040_0000, 32'h0040_0000, 32'h0040_0004));
        rows[1] = r(1, 0, 0, 0, e(1, 32'h0040_0008, 32'hE040_0004, 32'h0040_0004, 32'h0040_0008));
        rows[2] = r(1, 0, 0, 0, e(1, 32'h0040_000C, 32'hE040_0008, 32'h0040_0008, 32'h0040_000C));
        rows[3] = r(0, 0, 0, 0, e(1, 32'h0040_000C, 32'h0,         32'h0040_0008, 32'h0040_000C));
        foreach (rows[i]) begin
            Imem_Ack_IN = rows[i].ack; WANT_FREEZE_IN = rows[i].frz;
            Request_Alt_PC_IN = rows[i].redir; Alt_PC_IN = rows[i].alt;
            tick();
            if (obs() !== rows[i].exp) begin
                $display("FAIL stream[%0d] act=%h exp=%h", i, obs(), rows[i].exp);
                nerr++;
            end
            nvec++;
        end
    endtask

    task automatic test_latency();
        row_t rows[5];
        rows[0] = r(0, 0, 0, 0, e(1, 32'h0040_000C, 32'h0,         32'h0040_0008, 32'h0040_000C));
        rows[1] = r(1, 0, 0, 0, e(1, 32'h0040_0010, 32'hE040_000C, 32'h0040_000C, 32'h0040_0010));
        rows[2] = r(0, 0, 0, 0, e(1, 32'h0040_0010, 32'h0,         32'h0040_000C, 32'h0040_0010));
        rows[3] = r(0, 0, 0, 0, e(1, 32'h0040_0010, 32'h0,         32'h0040_000C, 32'h0040_0010));
        rows[4] = r(1, 0, 0, 0, e(1, 32'h0040_0014, 32'hE040_0010, 32'h0040_0010, 32'h0040_0014));
        foreach (rows[i]) begin
            Imem_Ack_IN = rows[i].ack; WANT_FREEZE_IN = rows[i].frz;
            Request_Alt_PC_IN = rows[i].redir; Alt_PC_IN = rows[i].alt;
            tick();
            if (obs() !== rows[i].exp) begin
                $display("FAIL latency[%0d] act=%h exp=%h", i, obs(), rows[i].exp);
                nerr++;
            end
            nvec++;
        end
    endtask

    task automatic test_freeze();
        row_t rows[3];
        rows[0] = r(1, 1, 0, 0, e(0, 32'h0040_0018, 32'hE040_0010, 32'h0040_0010, 32'h0040_0014));
        rows[1] = r(0, 1, 0, 0, e(0, 32'h0040_0018, 32'hE040_0010, 32'h0040_0010, 32'h0040_0014));
        rows[2] = r(0, 0, 0, 0, e(1, 32'h0040_0018, 32'hE040_0014, 32'h0040_0014, 32'h0040_0018));
        foreach (rows[i]) begin
            Imem_Ack_IN = rows[i].ack; WANT_FREEZE_IN = rows[i].frz;
            Request_Alt_PC_IN = rows[i].redir; Alt_PC_IN = rows[i].alt;
            tick();
            if (obs() !== rows[i].exp) begin
                $display("FAIL freeze[%0d] act=%h exp=%h", i, obs(), rows[i].exp);
                nerr++;
            end
            nvec++;
        end
    endtask

    task automatic test_redirect_same();
        row_t rows[2];
        rows[0] = r(1, 0, 1, 32'h0040_0103,
                    e(1, 32'h0040_0100, 32'h0,         32'h0040_0014, 32'h0040_0018));
        rows[1] = r(1, 0, 0, 0, e(1, 32'h0040_0104, 32'hE040_0100, 32'h0040_0100, 32'h0040_0104));
        foreach (rows[i]) begin
            Imem_Ack_IN = rows[i].ack; WANT_FREEZE_IN = rows[i].frz;
            Request_Alt_PC_IN = rows[i].redir; Alt_PC_IN = rows[i].alt;
            tick();
            if (obs() !== rows[i].exp) begin
                $display("FAIL redir_same[%0d] act=%h exp=%h", i, obs(), rows[i].exp);
                nerr++;
            end
            nvec++;
        end
    endtask

    task automatic test_redirect_latency();
        row_t rows[7];
        rows[0] = r(0, 0, 1, 32'h0040_0200,
                    e(1, 32'h0040_0104, 32'h0, 32'h0040_0100, 32'h0040_0104));
        rows[1] = r(0, 0, 0, 0, e(1, 32'h0040_0104, 32'h0, 32'h0040_0100, 32'h0040_0104));
        rows[2] = r(1, 0, 0, 0, e(1, 32'h0040_0200, 32'h0, 32'h0040_0100, 32'h0040_0104));
        rows[3] = r(0, 0, 1, 32'h0040_0300,
                    e(1, 32'h0040_0200, 32'h0, 32'h0040_0100, 32'h0040_0104));
        rows[4] = r(0, 0, 1, 32'h0040_0400,
                    e(1, 32'h0040_0200, 32'h0, 32'h0040_0100, 32'h0040_0104));
        rows[5] = r(1, 0, 0, 0, e(1, 32'h0040_0400, 32'h0, 32'h0040_0100, 32'h0040_0104));
        rows[6] = r(1, 0, 0, 0, e(1, 32'h0040_0404, 32'hE040_0400, 32'h0040_0400, 32'h0040_0404));
        foreach (rows[i]) begin
            Imem_Ack_IN = rows[i].ack; WANT_FREEZE_IN = rows[i].frz;
            Request_Alt_PC_IN = rows[i].redir; Alt_PC_IN = rows[i].alt;
            tick();
            if (obs() !== rows[i].exp) begin
                $display("FAIL redir_latency[%0d] act=%h exp=%h", i, obs(), rows[i].exp);
                nerr++;
            end
            nvec++;
        end
    endtask

    task automatic test_reset_mid();
        logic [128:0] want;
        // Leave a squash pending so reset must also clear it.
        Imem_Ack_IN = 1'b0; Request_Alt_PC_IN = 1'b1; Alt_PC_IN = 32'h0040_0500;
        tick();
        want = e(1'b1, 32'h0040_0404, 32'h0, 32'h0040_0400, 32'h0040_0404);
        if (obs() !== want) begin
            $display("FAIL rstmid_pre act=%h exp=%h", obs(), want);
            nerr++;
        end
        nvec++;
        Request_Alt_PC_IN = 1'b0;
        RESET = 1'b0;
        #1;
        want = e(1'b0, 32'h0040_0000, 32'h0, 32'h0, 32'h4);
        if (obs() !== want) begin
            $display("FAIL rstmid_async act=%h exp=%h", obs(), want);
            nerr++;
        end
        nvec++;
        #2 RESET = 1'b1;
        tick();
        want = e(1'b1, 32'h0040_0000, 32'h0, 32'h0, 32'h4);
        if (obs() !== want) begin
            $display("FAIL rstmid_req act=%h exp=%h", obs(), want);
            nerr++;
        end
        nvec++;
        Imem_Ack_IN = 1'b1;
        tick();
        want = e(1'b1, 32'h0040_0004, 32'hE040_0000, 32'h0040_0000, 32'h0040_0004);
        if (obs() !== want) begin
            $display("FAIL rstmid_word act=%h exp=%h", obs(), want);
            nerr++;
        end
        nvec++;
        Imem_Ack_IN = 1'b0;
    endtask

    initial begin
        Alt_PC_IN = '0;
        Request_Alt_PC_IN = 1'b0;
        WANT_FREEZE_IN = 1'b0;
        Imem_Ack_IN = 1'b0;
        test_reset();
        test_stream();
        test_latency();
        test_freeze();
        test_redirect_same();
        test_redirect_latency();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
